// File: rtl/compare_arbiter_pkg.sv
// Shared constants for the two-requester compare arbiter.
// Op codes follow the comparison display select codes.
package compare_arbiter_pkg;

   localparam int RSP_W = 8;

   localparam logic [1:0] OP_EQ  = 2'b00;
   localparam logic [1:0] OP_GT  = 2'b01;
   localparam logic [1:0] OP_LT  = 2'b10;
   localparam logic [1:0] OP_MAX = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_e;

endpackage

// File: rtl/compare_arbiter_compare_unit.sv
// Combinational compare: eq/gt/lt give a flag in bit 0, max gives the larger operand.
// Zero latency; no handshake, fed from the arbiter's operand registers.
module compare_unit
   import compare_arbiter_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]     x,
   input  logic [W-1:0]     y,
   input  logic [1:0]       op,
   output logic [RSP_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_EQ:   result[0]      = (x == y);
         OP_GT:   result[0]      = (x > y);
         OP_LT:   result[0]      = (x < y);
         default: result[W-1:0]  = (y > x) ? y : x;
      endcase
   end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin shares one compare unit between two requesters; IDLE -> EXEC -> RESP.
// Result registered one cycle after accept; RESP holds until rsp_ready, blocking new accepts.
module compare_arbiter
   import compare_arbiter_pkg::*;
#(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [W-1:0]     req0_x,
   input  logic [W-1:0]     req0_y,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [W-1:0]     req1_x,
   input  logic [W-1:0]     req1_y,
   input  logic [1:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [RSP_W-1:0] rsp_data,
   output logic             busy
);

   typedef struct packed {
      logic         id;
      logic [1:0]   op;
      logic [W-1:0] x;
      logic [W-1:0] y;
   } opnd_t;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   opnd_t            opnd_q, opnd_d;
   logic [RSP_W-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_id_q, rsp_id_d;
   logic             grant;
   logic             accept;
   logic [RSP_W-1:0] cmp_result;

   // Under contention the requester not served last wins; a lone requester always wins.
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = req1_valid;
      end
   end

   assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
   assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;

   compare_unit #(.W(W)) u_compare_unit (
      .x      (opnd_q.x),
      .y      (opnd_q.y),
      .op     (opnd_q.op),
      .result (cmp_result)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      opnd_d       = opnd_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               last_grant_d = grant;
               opnd_d.id    = grant;
               opnd_d.op    = grant ? req1_op : req0_op;
               opnd_d.x     = grant ? req1_x  : req0_x;
               opnd_d.y     = grant ? req1_y  : req0_y;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d = cmp_result;
            rsp_id_d   = opnd_q.id;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         opnd_q       <= '0;
         rsp_data_q   <= '0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         opnd_q       <= opnd_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter: vector table, arbitration/back-pressure/reset sequences, op sweep.
module tb_compare_arbiter;
   import compare_arbiter_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
   logic [1:0]   req0_op = '0, req1_op = '0;
   logic         rsp_valid, rsp_id, busy;
   logic         rsp_ready = 1'b1;
   logic [7:0]   rsp_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   compare_arbiter #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .busy       (busy)
   );

   typedef struct {
      logic       id;
      logic [3:0] x;
      logic [3:0] y;
      logic [1:0] op;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_cmp(input int x, input int y, input int op);
      case (op)
         0:       return (x == y) ? 8'd1 : 8'd0;
         1:       return (x > y)  ? 8'd1 : 8'd0;
         2:       return (x < y)  ? 8'd1 : 8'd0;
         default: return (x >= y) ? 8'(x) : 8'(y);
      endcase
   endfunction

   task automatic drive(input logic id, input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
      if (id) begin
         req1_valid = 1'b1; req1_x = x; req1_y = y; req1_op = op;
      end else begin
         req0_valid = 1'b1; req0_x = x; req0_y = y; req0_op = op;
      end
   endtask

   // Entered at a negedge in IDLE with requests already driven; returns at a negedge in IDLE.
   task automatic serve(input logic id, input logic [7:0] exp, input string name);
      int n;
      #1;
      check({name, "_rdy_win"},  id ? req1_ready : req0_ready, 1);
      check({name, "_rdy_lose"}, id ? req0_ready : req1_ready, 0);
      @(posedge clk);
      #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 6);
      check({name, "_lat"},  n, 2);
      check({name, "_id"},   rsp_id, id);
      check({name, "_data"}, rsp_data, exp);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 4'h5, 4'h5, OP_EQ,  8'h01};
      vecs[1]  = '{1'b0, 4'h5, 4'h6, OP_EQ,  8'h00};
      vecs[2]  = '{1'b1, 4'h3, 4'h9, OP_GT,  8'h00};
      vecs[3]  = '{1'b1, 4'h9, 4'h3, OP_GT,  8'h01};
      vecs[4]  = '{1'b0, 4'h3, 4'h9, OP_LT,  8'h01};
      vecs[5]  = '{1'b0, 4'hF, 4'h0, OP_LT,  8'h00};
      vecs[6]  = '{1'b1, 4'hA, 4'h3, OP_MAX, 8'h0A};
      vecs[7]  = '{1'b0, 4'h2, 4'hF, OP_MAX, 8'h0F};
      vecs[8]  = '{1'b1, 4'h7, 4'h7, OP_MAX, 8'h07};
      vecs[9]  = '{1'b0, 4'h4, 4'h4, OP_GT,  8'h00};
      vecs[10] = '{1'b1, 4'h0, 4'h0, OP_LT,  8'h00};
      vecs[11] = '{1'b0, 4'h0, 4'hF, OP_MAX, 8'h0F};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy",      busy, 0);
      check("rst_rsp_data",  rsp_data, 0);
      check("rst_rsp_id",    rsp_id, 0);
      check("rst_req0_rdy",  req0_ready, 0);
      check("rst_req1_rdy",  req1_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request, cycle by cycle
      drive(1'b0, 4'h5, 4'h5, OP_EQ);
      #1;
      check("single_rdy0", req0_ready, 1);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      check("single_exec_busy", busy, 1);
      check("single_exec_vld",  rsp_valid, 0);
      @(negedge clk);
      check("single_resp_vld",  rsp_valid, 1);
      check("single_resp_data", rsp_data, 8'h01);
      check("single_resp_id",   rsp_id, 0);
      @(negedge clk);
      check("single_idle_busy", busy, 0);
      check("single_idle_vld",  rsp_valid, 0);

      // Table of single-requester vectors
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].op);
         serve(vecs[i].id, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Contention from reset, then alternation
      do_reset();
      drive(1'b0, 4'h3, 4'h9, OP_GT);
      drive(1'b1, 4'h3, 4'h9, OP_LT);
      #1;
      check("cont_rdy0", req0_ready, 1);
      check("cont_rdy1", req1_ready, 0);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      check("cont_exec_rdy1", req1_ready, 0);
      @(negedge clk);
      check("cont_r1_vld",  rsp_valid, 1);
      check("cont_r1_id",   rsp_id, 0);
      check("cont_r1_data", rsp_data, 8'h00);
      check("cont_resp_rdy1", req1_ready, 0);
      @(negedge clk);
      serve(1'b1, 8'h01, "cont_r2");
      drive(1'b0, 4'h1, 4'h1, OP_EQ);
      drive(1'b1, 4'h2, 4'h5, OP_MAX);
      serve(1'b0, 8'h01, "alt_a");
      drive(1'b0, 4'h6, 4'h1, OP_GT);
      serve(1'b1, 8'h05, "alt_b");
      drive(1'b1, 4'h9, 4'hB, OP_MAX);
      serve(1'b0, 8'h01, "alt_c");
      serve(1'b1, 8'h0B, "alt_d");

      // Response back-pressure
      rsp_ready = 1'b0;
      drive(1'b0, 4'hC, 4'h4, OP_MAX);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      drive(1'b1, 4'h6, 4'h6, OP_EQ);
      @(negedge clk);
      check("bp_exec_rdy1", req1_ready, 0);
      @(negedge clk);
      check("bp_vld",  rsp_valid, 1);
      check("bp_data", rsp_data, 8'h0C);
      check("bp_id",   rsp_id, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp_hold_vld%0d", c),  rsp_valid, 1);
         check($sformatf("bp_hold_data%0d", c), rsp_data, 8'h0C);
         check($sformatf("bp_hold_rdy1%0d", c), req1_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_vld", rsp_valid, 0);
      serve(1'b1, 8'h01, "bp_req1");

      // Asynchronous reset during EXEC
      drive(1'b0, 4'h1, 4'h2, OP_LT);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      check("mid_exec_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_vld",  rsp_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", rsp_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("mid_norsp%0d", c), rsp_valid, 0);
      end
      drive(1'b0, 4'h8, 4'h8, OP_MAX);
      drive(1'b1, 4'h2, 4'h1, OP_GT);
      serve(1'b0, 8'h08, "post_rst");
      req1_valid = 1'b0;

      // Every operand pair for every op through requester 1
      for (int op = 0; op < 4; op++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               drive(1'b1, x[3:0], y[3:0], op[1:0]);
               serve(1'b1, ref_cmp(x, y, op), $sformatf("sweep_op%0d_x%0h_y%0h", op, x, y));
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
